// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Purpose : shared definitions for the video timing generator: the per-axis
//           phase encoding, the default 800x480 panel timing and a helper
//           that sums the four phase lengths into a total period.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package video_pkg;

    // Phase order along an axis, starting from count 0.
    typedef enum logic [1:0] {
        DISP  = 2'd0,
        FP    = 2'd1,
        PULSE = 2'd2,
        BP    = 2'd3
    } phase_t;

    // Default panel timing (800x480 at a 32 MHz pixel clock).
    localparam int H_DISP_DEF  = 800;
    localparam int H_FP_DEF    = 40;
    localparam int H_PULSE_DEF = 48;
    localparam int H_BP_DEF    = 40;
    localparam int V_DISP_DEF  = 480;
    localparam int V_FP_DEF    = 13;
    localparam int V_PULSE_DEF = 3;
    localparam int V_BP_DEF    = 29;

    function automatic int total(input int disp, input int fp,
                                 input int pulse, input int bp);
        return disp + fp + pulse + bp;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// ---------------------------------------------------------------------------
// timing_axis
// Purpose : one axis (horizontal or vertical) of the video timing. A counter
//           runs 0..TOTAL-1 and a 4-state phase FSM tracks DISP/FP/PULSE/BP
//           alongside it. The counter advances only when step is high.
// Ports   : clk   in   clock, rising edge
//           rst   in   asynchronous active-high reset
//           en    in   run enable; low forces the axis back to its origin
//           step  in   advance by one count this cycle
//           cnt   out  current count
//           phase out  current phase (matches cnt)
//           wrap  out  high while cnt is at its last value
// ---------------------------------------------------------------------------
module timing_axis
    import video_pkg::*;
#(
    parameter int DISP_LEN  = H_DISP_DEF,
    parameter int FP_LEN    = H_FP_DEF,
    parameter int PULSE_LEN = H_PULSE_DEF,
    parameter int BP_LEN    = H_BP_DEF,
    parameter int CNT_W     = $clog2(total(DISP_LEN, FP_LEN, PULSE_LEN, BP_LEN))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output phase_t           phase,
    output logic             wrap
);

    localparam int TOTAL = total(DISP_LEN, FP_LEN, PULSE_LEN, BP_LEN);

    // Last count of each phase; the FSM moves on when cnt reaches it.
    localparam logic [CNT_W-1:0] DISP_END  = CNT_W'(DISP_LEN - 1);
    localparam logic [CNT_W-1:0] FP_END    = CNT_W'(DISP_LEN + FP_LEN - 1);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(DISP_LEN + FP_LEN + PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);

    // A zero-length phase would make two boundaries coincide and the FSM
    // would skip a state, so such timings are rejected at elaboration.
    generate
        if (DISP_LEN < 1 || FP_LEN < 1 || PULSE_LEN < 1 || BP_LEN < 1) begin : g_bad_phase
            $error("timing_axis: every phase length must be at least 1");
        end
        if (TOTAL > (1 << CNT_W)) begin : g_bad_width
            $error("timing_axis: CNT_W too small for the axis period");
        end
    endgenerate

    assign wrap = (cnt == LAST);

    // Counter and phase FSM advance together so phase always describes cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= DISP;
        end else if (!en) begin
            cnt   <= '0;
            phase <= DISP;
        end else if (step) begin
            if (wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            case (phase)
                DISP:  if (cnt == DISP_END)  phase <= FP;
                FP:    if (cnt == FP_END)    phase <= PULSE;
                PULSE: if (cnt == PULSE_END) phase <= BP;
                BP:    if (wrap)             phase <= DISP;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Purpose : video timing generator for the pixel clock domain. Two timing_axis
//           instances produce the counters; this level only registers the
//           decoded sync, blank, coordinate and request outputs.
// Ports   : pixel_clk   in   pixel clock, rising edge
//           pixel_rst   in   asynchronous active-high reset
//           en          in   run enable; low idles at the origin
//           vga_hs      out  horizontal sync, active low
//           vga_vs      out  vertical sync, active low
//           vga_blank   out  high during active display
//           pix_x       out  column of the current active pixel
//           pix_y       out  line of the current active pixel
//           pix_req     out  high one cycle before each active pixel
//           line_start  out  one-cycle pulse at hcnt==0
//           frame_start out  one-cycle pulse at hcnt==0 && vcnt==0
// ---------------------------------------------------------------------------
module vga_timing_gen
    import video_pkg::*;
#(
    parameter int HDISP  = H_DISP_DEF,
    parameter int HFP    = H_FP_DEF,
    parameter int HPULSE = H_PULSE_DEF,
    parameter int HBP    = H_BP_DEF,
    parameter int VDISP  = V_DISP_DEF,
    parameter int VFP    = V_FP_DEF,
    parameter int VPULSE = V_PULSE_DEF,
    parameter int VBP    = V_BP_DEF
) (
    input  logic                     pixel_clk,
    input  logic                     pixel_rst,
    input  logic                     en,
    output logic                     vga_hs,
    output logic                     vga_vs,
    output logic                     vga_blank,
    output logic [$clog2(HDISP)-1:0] pix_x,
    output logic [$clog2(VDISP)-1:0] pix_y,
    output logic                     pix_req,
    output logic                     line_start,
    output logic                     frame_start
);

    localparam int X_W = $clog2(HDISP);
    localparam int Y_W = $clog2(VDISP);
    localparam int H_W = $clog2(total(HDISP, HFP, HPULSE, HBP));
    localparam int V_W = $clog2(total(VDISP, VFP, VPULSE, VBP));

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    phase_t         h_phase;
    phase_t         v_phase;
    logic           h_wrap;

    // Coordinates captured alongside pix_req, moved to pix_x/pix_y one
    // cycle later so they line up with vga_blank.
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;

    timing_axis #(
        .DISP_LEN (HDISP),
        .FP_LEN   (HFP),
        .PULSE_LEN(HPULSE),
        .BP_LEN   (HBP),
        .CNT_W    (H_W)
    ) u_h_axis (
        .clk  (pixel_clk),
        .rst  (pixel_rst),
        .en   (en),
        .step (1'b1),
        .cnt  (h_cnt),
        .phase(h_phase),
        .wrap (h_wrap)
    );

    // The vertical axis advances once per line, on the last pixel of the line,
    // so the line/frame wrap lands on the same edge.
    timing_axis #(
        .DISP_LEN (VDISP),
        .FP_LEN   (VFP),
        .PULSE_LEN(VPULSE),
        .BP_LEN   (VBP),
        .CNT_W    (V_W)
    ) u_v_axis (
        .clk  (pixel_clk),
        .rst  (pixel_rst),
        .en   (en),
        .step (h_wrap),
        .cnt  (v_cnt),
        .phase(v_phase),
        .wrap ()
    );

    // Registered decode. Sync, pulses and pix_req reflect the counters of the
    // previous cycle; vga_blank and the coordinates follow pix_req one cycle
    // later, which is what makes pix_req an early request. While en is low
    // every output is held at its reset value, so nothing survives a restart.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_req     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else if (!en) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_req     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            vga_hs      <= (h_phase != PULSE);
            vga_vs      <= (v_phase != PULSE);
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            pix_req     <= (h_phase == DISP) && (v_phase == DISP);
            x_q         <= h_cnt[X_W-1:0];
            y_q         <= v_cnt[Y_W-1:0];
            vga_blank   <= pix_req;
            if (pix_req) begin
                pix_x <= x_q;
                pix_y <= y_q;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Purpose : directed bench for vga_timing_gen. One instance uses the default
//           800x480 timing for line-level behaviour; a second, tiny instance
//           (15 x 10 total) shares the same inputs so whole frames fit in a
//           short run.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic pixel_clk = 1'b0;
    logic pixel_rst;
    logic en;

    logic       vga_hs, vga_vs, vga_blank, pix_req, line_start, frame_start;
    logic [9:0] pix_x;
    logic [8:0] pix_y;

    // Small instance: H 8/2/3/2 (15), V 4/2/3/1 (10) -> 150-cycle frame.
    logic       s_hs, s_vs, s_blank, s_req, s_ls, s_fs;
    logic [2:0] s_x;
    logic [1:0] s_y;

    int check_count = 0;
    int error_count = 0;

    vga_timing_gen dut (
        .pixel_clk  (pixel_clk),
        .pixel_rst  (pixel_rst),
        .en         (en),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_blank  (vga_blank),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_req    (pix_req),
        .line_start (line_start),
        .frame_start(frame_start)
    );

    vga_timing_gen #(
        .HDISP(8), .HFP(2), .HPULSE(3), .HBP(2),
        .VDISP(4), .VFP(2), .VPULSE(3), .VBP(1)
    ) dut_s (
        .pixel_clk  (pixel_clk),
        .pixel_rst  (pixel_rst),
        .en         (en),
        .vga_hs     (s_hs),
        .vga_vs     (s_vs),
        .vga_blank  (s_blank),
        .pix_x      (s_x),
        .pix_y      (s_y),
        .pix_req    (s_req),
        .line_start (s_ls),
        .frame_start(s_fs)
    );

    always #15.625 pixel_clk = ~pixel_clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed != expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic en_v);
        pixel_rst = rst_v;
        en        = en_v;
    endtask

    // Advance one edge and leave the bench 1 ns after it for sampling.
    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic checkIdle(input string prefix);
        checkOutput({prefix, "_hs"},     vga_hs,      1);
        checkOutput({prefix, "_vs"},     vga_vs,      1);
        checkOutput({prefix, "_blank"},  vga_blank,   0);
        checkOutput({prefix, "_pix_x"},  pix_x,       0);
        checkOutput({prefix, "_pix_y"},  pix_y,       0);
        checkOutput({prefix, "_req"},    pix_req,     0);
        checkOutput({prefix, "_ls"},     line_start,  0);
        checkOutput({prefix, "_fs"},     frame_start, 0);
        checkOutput({prefix, "_s_blank"}, s_blank,    0);
        checkOutput({prefix, "_s_x"},    s_x,         0);
        checkOutput({prefix, "_s_req"},  s_req,       0);
        checkOutput({prefix, "_s_vs"},   s_vs,        1);
    endtask

    // Checks for the first two edges after a (re)start at the origin.
    task automatic checkStart(input string prefix);
        tick();
        checkOutput({prefix, "_fs"},    frame_start, 1);
        checkOutput({prefix, "_ls"},    line_start,  1);
        checkOutput({prefix, "_hs"},    vga_hs,      1);
        checkOutput({prefix, "_vs"},    vga_vs,      1);
        checkOutput({prefix, "_req"},   pix_req,     1);
        checkOutput({prefix, "_blank"}, vga_blank,   0);
        checkOutput({prefix, "_s_fs"},  s_fs,        1);
        tick();
        checkOutput({prefix, "_blank2"}, vga_blank,   1);
        checkOutput({prefix, "_x0"},     pix_x,       0);
        checkOutput({prefix, "_y0"},     pix_y,       0);
        checkOutput({prefix, "_ls2"},    line_start,  0);
        checkOutput({prefix, "_fs2"},    frame_start, 0);
    endtask

    initial begin
        int blank_n = 0, req_n = 0, hs_low_n = 0, hs_first = 0, ls_second = 0;
        int s_ls_n = 0, s_req_n = 0, s_blank_n = 0, s_vs_low_n = 0;
        int s_vs_first = 0, s_fs_second = 0, idle_busy_n = 0;

        applyStimulus(1'b1, 1'b0);
        repeat (3) tick();
        checkIdle("reset");

        // Release reset with en high; edge 1 is the first counted edge.
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1);

        for (int i = 1; i <= 929; i++) begin
            tick();
            if (i == 1) begin
                checkOutput("start_fs",    frame_start, 1);
                checkOutput("start_ls",    line_start,  1);
                checkOutput("start_hs",    vga_hs,      1);
                checkOutput("start_vs",    vga_vs,      1);
                checkOutput("start_req",   pix_req,     1);
                checkOutput("start_blank", vga_blank,   0);
                checkOutput("start_s_fs",  s_fs,        1);
                checkOutput("start_s_ls",  s_ls,        1);
            end
            if (i == 2) begin
                checkOutput("first_blank", vga_blank,   1);
                checkOutput("first_x",     pix_x,       0);
                checkOutput("first_y",     pix_y,       0);
                checkOutput("first_ls",    line_start,  0);
            end
            if (i == 801) begin
                checkOutput("last_blank", vga_blank, 1);
                checkOutput("last_x",     pix_x,     799);
            end
            if (i == 802) begin
                checkOutput("hblank",      vga_blank, 0);
                checkOutput("hold_x_early", pix_x,    799);
            end
            if (i <= 928) begin
                blank_n += int'(vga_blank);
                req_n   += int'(pix_req);
                if (!vga_hs) begin
                    hs_low_n++;
                    if (hs_first == 0) hs_first = i;
                end
            end
            if (line_start && i > 1 && ls_second == 0) ls_second = i;

            if (i <= 150) begin
                s_ls_n  += int'(s_ls);
                s_req_n += int'(s_req);
                if (!s_vs) begin
                    s_vs_low_n++;
                    if (s_vs_first == 0) s_vs_first = i;
                end
            end
            if (i >= 2 && i <= 151) s_blank_n += int'(s_blank);
            if (s_fs && i > 1 && s_fs_second == 0) s_fs_second = i;
            if (i == 54) begin
                checkOutput("s_last_blank", s_blank, 1);
                checkOutput("s_last_x",     s_x,     7);
                checkOutput("s_last_y",     s_y,     3);
            end
            if (i == 150) begin
                checkOutput("s_vblank",  s_blank, 0);
                checkOutput("s_hold_x",  s_x,     7);
                checkOutput("s_hold_y",  s_y,     3);
            end
        end

        checkOutput("blank_cycles",  blank_n,   800);
        checkOutput("req_cycles",    req_n,     800);
        checkOutput("hs_low_cycles", hs_low_n,  48);
        checkOutput("hs_offset",     hs_first - 1, 840);
        checkOutput("line_period",   ls_second - 1, 928);
        checkOutput("hold_x_late",   pix_x,     799);
        checkOutput("hold_y_late",   pix_y,     0);
        checkOutput("s_lines",       s_ls_n,    10);
        checkOutput("s_req_total",   s_req_n,   32);
        checkOutput("s_blank_total", s_blank_n, 32);
        checkOutput("s_vs_low",      s_vs_low_n, 45);
        checkOutput("s_vs_start",    s_vs_first, 91);
        checkOutput("s_frame_period", s_fs_second - 1, 150);

        // Move to column 398 of line 1, then reset between edges.
        repeat (1328 - 929) tick();
        checkOutput("pre_rst_blank", vga_blank, 1);
        checkOutput("pre_rst_x",     pix_x,     398);
        checkOutput("pre_rst_y",     pix_y,     1);
        #5;
        applyStimulus(1'b1, 1'b1);
        #1;
        checkIdle("async_rst");
        tick();
        applyStimulus(1'b0, 1'b1);
        checkStart("restart");

        // Drop en mid-line for 10 cycles.
        repeat (98) tick();
        checkOutput("pre_en_x", pix_x, 98);
        applyStimulus(1'b0, 1'b0);
        tick();
        checkIdle("en_low");
        for (int i = 0; i < 9; i++) begin
            tick();
            if (vga_blank || pix_req || line_start || frame_start || !vga_hs) idle_busy_n++;
        end
        checkOutput("en_low_quiet", idle_busy_n, 0);
        applyStimulus(1'b0, 1'b1);
        checkStart("reenable");

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
